// File: rtl/xoodoo_perm_ctrl.sv
// Round sequencer for the 2-share masked Xoodoo datapath: loads shares, fetches one
// PRNG word per round, and iterates the datapath NROUNDS times through its share registers.
module xoodoo_perm_ctrl #(
    parameter int unsigned NROUNDS   = 12,
    parameter int unsigned ROUND_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [383:0] din0_i,
    input  logic [383:0] din1_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [383:0] dout0_o,
    output logic [383:0] dout1_o,
    input  logic         rnd_valid_i,
    input  logic [383:0] rnd_data_i,
    output logic         rnd_ready_o,
    output logic         dp_rst_o,
    output logic [383:0] dp_state0_o,
    output logic [383:0] dp_state1_o,
    input  logic [383:0] dp_state0_i,
    input  logic [383:0] dp_state1_i,
    output logic [12:0]  dp_j_o,
    input  logic [12:0]  dp_j_i,
    output logic [383:0] dp_rdi_o,
    output logic         dp_rdi_en_o
);

    localparam int unsigned W   = 384;
    localparam int unsigned JW  = 13;
    localparam int unsigned RCW = 4;
    localparam int unsigned WCW = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   sh0_q, sh0_d;
    logic [W-1:0]   sh1_q, sh1_d;
    logic [W-1:0]   rdi_q, rdi_d;
    logic [JW-1:0]  j_q, j_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           dp_rst_q, dp_rst_d;

    // Next-state logic; abort overrides any handshake or round commit in the same cycle.
    always_comb begin
        state_d  = state_q;
        sh0_d    = sh0_q;
        sh1_d    = sh1_q;
        rdi_d    = rdi_q;
        j_d      = j_q;
        rcnt_d   = rcnt_q;
        wcnt_d   = wcnt_q;
        dp_rst_d = 1'b0;

        if ((state_q != S_IDLE) && abort_i) begin
            state_d  = S_IDLE;
            sh0_d    = '0;
            sh1_d    = '0;
            rdi_d    = '0;
            j_d      = '0;
            rcnt_d   = '0;
            wcnt_d   = '0;
            dp_rst_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        sh0_d   = din0_i;
                        sh1_d   = din1_i;
                        j_d     = JW'(1);
                        rcnt_d  = '0;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (rnd_valid_i) begin
                        rdi_d   = rnd_data_i;
                        wcnt_d  = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == WCW'(ROUND_LAT - 1)) begin
                        sh0_d   = dp_state0_i;
                        sh1_d   = dp_state1_i;
                        j_d     = dp_j_i;
                        rcnt_d  = rcnt_q + RCW'(1);
                        state_d = (rcnt_q == RCW'(NROUNDS - 1)) ? S_DONE : S_ISSUE;
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end
                S_DONE: begin
                    // Randomness must not linger once the result has been handed over.
                    rdi_d   = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sh0_q    <= '0;
            sh1_q    <= '0;
            rdi_q    <= '0;
            j_q      <= '0;
            rcnt_q   <= '0;
            wcnt_q   <= '0;
            dp_rst_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            sh0_q    <= sh0_d;
            sh1_q    <= sh1_d;
            rdi_q    <= rdi_d;
            j_q      <= j_d;
            rcnt_q   <= rcnt_d;
            wcnt_q   <= wcnt_d;
            dp_rst_q <= dp_rst_d;
        end
    end

    // Outputs are decoded straight from registers, except the abort gating of rnd_ready_o.
    assign ready_o     = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign rnd_ready_o = (state_q == S_ISSUE) && !abort_i;
    assign dp_rdi_en_o = (state_q == S_WAIT);
    assign dp_rst_o    = dp_rst_q;
    assign dout0_o     = sh0_q;
    assign dout1_o     = sh1_q;
    assign dp_state0_o = sh0_q;
    assign dp_state1_o = sh1_q;
    assign dp_j_o      = j_q;
    assign dp_rdi_o    = rdi_q;

endmodule

// File: tb/tb_xoodoo_perm_ctrl.sv
// Bench for xoodoo_perm_ctrl: behavioural masked Xoodoo round as the datapath,
// table-driven permutation calls plus hand-written abort and reset sequences.
module tb_xoodoo_perm_ctrl;

    localparam int unsigned NR  = 12;
    localparam int unsigned LAT = 2;
    localparam int unsigned W   = 384;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic         abort_i;
    logic [W-1:0] din0_i, din1_i;
    logic         ready_o, busy_o, done_o;
    logic [W-1:0] dout0_o, dout1_o;
    logic         rnd_valid_i;
    logic [W-1:0] rnd_data_i;
    logic         rnd_ready_o;
    logic         dp_rst_o;
    logic [W-1:0] dp_state0_o, dp_state1_o;
    logic [W-1:0] dp_state0_i, dp_state1_i;
    logic [12:0]  dp_j_o, dp_j_i;
    logic [W-1:0] dp_rdi_o;
    logic         dp_rdi_en_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] word_ctr = 32'h1000_0001;

    xoodoo_perm_ctrl #(.NROUNDS(NR), .ROUND_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .din0_i(din0_i), .din1_i(din1_i), .ready_o(ready_o), .busy_o(busy_o),
        .done_o(done_o), .dout0_o(dout0_o), .dout1_o(dout1_o),
        .rnd_valid_i(rnd_valid_i), .rnd_data_i(rnd_data_i), .rnd_ready_o(rnd_ready_o),
        .dp_rst_o(dp_rst_o), .dp_state0_o(dp_state0_o), .dp_state1_o(dp_state1_o),
        .dp_state0_i(dp_state0_i), .dp_state1_i(dp_state1_i),
        .dp_j_o(dp_j_o), .dp_j_i(dp_j_i), .dp_rdi_o(dp_rdi_o), .dp_rdi_en_o(dp_rdi_en_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] rc_idx(input int i);
        case (i)
            0: return 32'h058;  1: return 32'h038;  2: return 32'h3C0;  3: return 32'h0D0;
            4: return 32'h120;  5: return 32'h014;  6: return 32'h060;  7: return 32'h02C;
            8: return 32'h380;  9: return 32'h0F0; 10: return 32'h1A0; 11: return 32'h012;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rc_of(input logic [12:0] j);
        logic [31:0] rc = '0;
        for (int k = 0; k < 12; k++) if (j[k]) rc |= rc_idx(k);
        return rc;
    endfunction

    // One unmasked Xoodoo round; lane (y,x) sits at bits [32*(4y+x) +: 32].
    function automatic logic [W-1:0] xround(input logic [W-1:0] s, input logic [31:0] rc);
        logic [31:0] a [3][4];
        logic [31:0] b [3][4];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [31:0] t [4];
        logic [W-1:0] r;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] = s[32*(4*y+x) +: 32];
        for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] ^= e[x];
        t = a[1];
        for (int x = 0; x < 4; x++) begin
            a[1][x] = t[(x+3)%4];
            a[2][x] = rotl(a[2][x], 11);
        end
        a[0][0] ^= rc;
        for (int x = 0; x < 4; x++) begin
            b[0][x] = ~a[1][x] & a[2][x];
            b[1][x] = ~a[2][x] & a[0][x];
            b[2][x] = ~a[0][x] & a[1][x];
        end
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] ^= b[y][x];
        t = a[2];
        for (int x = 0; x < 4; x++) begin
            a[1][x] = rotl(a[1][x], 1);
            a[2][x] = rotl(t[(x+2)%4], 8);
        end
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) r[32*(4*y+x) +: 32] = a[y][x];
        return r;
    endfunction

    function automatic logic [W-1:0] golden(input logic [W-1:0] s);
        logic [W-1:0] v = s;
        for (int r = 0; r < int'(NR); r++) v = xround(v, rc_idx(r));
        return v;
    endfunction

    function automatic logic [W-1:0] rand384();
        logic [W-1:0] v;
        for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // Datapath model: valid output only in the last cycle of the latency window.
    int lat_cnt = 0;
    always @(posedge clk) lat_cnt <= dp_rdi_en_o ? lat_cnt + 1 : 0;

    always_comb begin
        dp_state0_i = ~dp_state0_o;
        dp_state1_i = dp_state1_o ^ {12{32'hDEAD_BEEF}};
        dp_j_i      = 13'h1555;
        if (dp_rdi_en_o && (lat_cnt == int'(LAT) - 1)) begin
            dp_state0_i = xround(dp_state0_o ^ dp_state1_o, rc_of(dp_j_o)) ^ dp_rdi_o;
            dp_state1_i = dp_rdi_o;
            dp_j_i      = dp_j_o << 1;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        int           stall_round;
        int           stall_len;
        bit           busy_start;
        int           exp_done;
    } vec_t;

    // Cycle 0 is the IDLE cycle with start_i high; the bench observes each cycle at posedge+1.
    task automatic run_call(input vec_t v);
        int cyc = 0, r_issue = 0, hs = 0, done_cnt = 0, done_cyc = -1, exp_c;
        int stall_left = v.stall_len;
        bit prev_issue = 1'b0;
        logic [W-1:0] word_acc = '0;
        logic [W-1:0] exp_res = golden(v.d0 ^ v.d1);
        din0_i = v.d0;
        din1_i = v.d1;
        start_i = 1'b1;
        rnd_valid_i = 1'b1;
        while (cyc < 80 && !(done_cnt > 0 && cyc > done_cyc + 1)) begin
            tick();
            cyc++;
            start_i = v.busy_start && (cyc == 10);
            if (v.busy_start && cyc == 10) begin
                din0_i = ~v.d0;
                din1_i = rand384();
            end
            rnd_data_i = {12{word_ctr}};
            rnd_valid_i = 1'b1;
            if (rnd_ready_o) begin
                if (!prev_issue) begin
                    exp_c = 1 + r_issue * (1 + int'(LAT)) +
                            ((v.stall_round >= 0 && r_issue > v.stall_round) ? v.stall_len : 0);
                    check("issue_cycle", W'(cyc), W'(exp_c));
                    check("dp_j", W'(dp_j_o), W'(13'(1) << r_issue));
                end
                if (r_issue == v.stall_round && stall_left > 0) begin
                    rnd_valid_i = 1'b0;
                    stall_left--;
                    check("stall_rdi_en", W'(dp_rdi_en_o), W'(0));
                end else begin
                    hs++;
                    word_acc = rnd_data_i;
                    word_ctr++;
                    r_issue++;
                end
            end
            prev_issue = rnd_ready_o;
            if (dp_rdi_en_o) check("rdi_hold", dp_rdi_o, word_acc);
            if (done_o) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
                check("result", dout0_o ^ dout1_o, exp_res);
            end
            if (done_cnt > 0 && cyc == done_cyc + 1) begin
                check("ready_after_done", W'(ready_o), W'(1));
                check("rdi_cleared", dp_rdi_o, W'(0));
                check("result_held", dout0_o ^ dout1_o, exp_res);
            end
        end
        start_i = 1'b0;
        check("done_cycle", W'(done_cyc), W'(v.exp_done));
        check("done_count", W'(done_cnt), W'(1));
        check("handshakes", W'(hs), W'(NR));
    endtask

    // Starts a call and advances to the given cycle without checking.
    task automatic start_and_run(input int to_cyc);
        din0_i = rand384();
        din1_i = rand384();
        start_i = 1'b1;
        rnd_valid_i = 1'b1;
        for (int c = 1; c <= to_cyc; c++) begin
            tick();
            start_i = 1'b0;
            rnd_data_i = {12{word_ctr}};
            if (rnd_ready_o) word_ctr++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs [5];
    logic [W-1:0] x_val, a_val, b_val;

    initial begin
        x_val = rand384();
        a_val = rand384();
        b_val = rand384();
        vecs[0] = '{x_val, x_val, -1, 0, 1'b0, 37};
        vecs[1] = '{x_val, x_val,  3, 5, 1'b0, 42};
        vecs[2] = '{a_val, b_val,  3, 5, 1'b0, 42};
        vecs[3] = '{a_val, b_val, -1, 0, 1'b1, 37};
        vecs[4] = '{b_val, a_val,  0, 2, 1'b0, 39};

        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; rnd_valid_i = 1'b0;
        rnd_data_i = '0; din0_i = '0; din1_i = '0;
        tick();
        tick();
        check("rst_ready", W'(ready_o), W'(1));
        check("rst_busy", W'(busy_o), W'(0));
        check("rst_done", W'(done_o), W'(0));
        check("rst_rnd_ready", W'(rnd_ready_o), W'(0));
        check("rst_rdi_en", W'(dp_rdi_en_o), W'(0));
        check("rst_dp_rst", W'(dp_rst_o), W'(1));
        check("rst_dout0", dout0_o, W'(0));
        rst_n = 1'b1;
        #1;
        check("dp_rst_before_edge", W'(dp_rst_o), W'(1));
        tick();
        check("dp_rst_after_edge", W'(dp_rst_o), W'(0));

        for (int i = 0; i < 5; i++) run_call(vecs[i]);

        // Abort in the second WAIT cycle of round 6.
        start_and_run(21);
        check("abort_in_wait", W'(dp_rdi_en_o), W'(1));
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_ready", W'(ready_o), W'(1));
        check("abort_busy", W'(busy_o), W'(0));
        check("abort_done", W'(done_o), W'(0));
        check("abort_dout0", dout0_o, W'(0));
        check("abort_dout1", dout1_o, W'(0));
        check("abort_j", W'(dp_j_o), W'(0));
        check("abort_dp_rst", W'(dp_rst_o), W'(1));
        tick();
        check("abort_dp_rst_clr", W'(dp_rst_o), W'(0));
        check("abort_no_done", W'(done_o), W'(0));

        // Abort in ISSUE with a valid PRNG word: word must not be taken.
        start_and_run(4);
        abort_i = 1'b1;
        rnd_valid_i = 1'b1;
        #1;
        check("abort_gates_rnd_ready", W'(rnd_ready_o), W'(0));
        tick();
        abort_i = 1'b0;
        check("abort_issue_ready", W'(ready_o), W'(1));
        check("abort_issue_rdi", dp_rdi_o, W'(0));
        run_call(vecs[0]);

        // Asynchronous reset in the first WAIT cycle of round 5.
        start_and_run(17);
        check("rst_mid_in_wait", W'(dp_rdi_en_o), W'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", W'(ready_o), W'(1));
        check("rst_mid_done", W'(done_o), W'(0));
        check("rst_mid_rnd_ready", W'(rnd_ready_o), W'(0));
        check("rst_mid_rdi_en", W'(dp_rdi_en_o), W'(0));
        check("rst_mid_dout0", dout0_o, W'(0));
        check("rst_mid_dout1", dout1_o, W'(0));
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_mid_dp_rst", W'(dp_rst_o), W'(1));
        tick();
        check("rst_mid_dp_rst_clr", W'(dp_rst_o), W'(0));
        run_call(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xoodoo_perm_ctrl.md
Name: xoodoo_perm_ctrl

Overview:
Sequencer for the masked (2-share, DOM first-order) Xoodoo single-round datapath. It loads the two input shares on start and iterates the datapath NROUNDS times through its own share registers. Each round it drives the one-hot round index and fetches fresh 384-bit randomness from the PRNG over a valid/ready handshake. It sits between the Xoodyak mode FSM and the round datapath, which has a synchronous active-high clear.

Parameters:
NROUNDS, 12, rounds per permutation call (1..12)
ROUND_LAT, 2, cycles from datapath input/index valid to datapath output valid (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  start permutation; sampled only in IDLE
abort_i  in  1  abandon current call; sampled in any non-IDLE state
din0_i  in  384  input share 0
din1_i  in  384  input share 1
ready_o  out  1  high in IDLE only
busy_o  out  1  high in ISSUE/WAIT/DONE
done_o  out  1  one-cycle pulse; dout valid
dout0_o  out  384  output share 0 (share register 0)
dout1_o  out  384  output share 1 (share register 1)
rnd_valid_i  in  1  PRNG word valid
rnd_data_i  in  384  PRNG word
rnd_ready_o  out  1  PRNG word accepted when valid&ready
dp_rst_o  out  1  datapath synchronous clear
dp_state0_o  out  384  datapath share-0 input (= share register 0)
dp_state1_o  out  384  datapath share-1 input (= share register 1)
dp_state0_i  in  384  datapath share-0 output
dp_state1_i  in  384  datapath share-1 output
dp_j_o  out  13  one-hot round index to datapath
dp_j_i  in  13  shifted index returned by datapath
dp_rdi_o  out  384  randomness to datapath (rdi register)
dp_rdi_en_o  out  1  randomness enable

Behaviour:
- Async reset (rst_n=0):
  - State IDLE; share regs, rdi reg, j reg and round counter all 0.
  - done_o=0, rnd_ready_o=0, dp_rdi_en_o=0, dp_rst_o=1.
- dp_rst_o stays 1 until the first clk edge after rst_n rises, then 0. It is also 1 for one cycle on abort.
- FSM: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Waits for start_i=1.
  - At that edge: share regs <= din0_i/din1_i; j reg <= 13'h0001; round counter <= 0; go to ISSUE.
- ISSUE:
  - rnd_ready_o=1.
  - If rnd_valid_i=0, hold in ISSUE (stall). Stall length is unbounded; no timeout.
  - On handshake: rdi reg <= rnd_data_i; wait counter <= 0; go to WAIT.
- WAIT:
  - dp_rdi_en_o=1 and rnd_ready_o=0.
  - Lasts exactly ROUND_LAT cycles.
  - At the edge ending the last WAIT cycle:
    - share regs <= dp_state0_i/dp_state1_i;
    - j reg <= dp_j_i;
    - round counter increments;
    - if counter was NROUNDS-1 go to DONE, else go to ISSUE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Output hold: dout0_o/dout1_o = share registers, held stable from DONE until the next start accepted.
- Input stability: dp_state*_o and dp_j_o stay stable from the ISSUE cycle through the last WAIT cycle. dp_rdi_o stays stable for all WAIT cycles of that round.
- Per-round randomness: exactly one PRNG word consumed per round. A word is never reused across rounds.
- Latency with no stalls:
  - Each round takes 1+ROUND_LAT cycles.
  - done_o is high NROUNDS*(1+ROUND_LAT)+1 cycles after the start-accept cycle (37 for defaults).
  - Each ISSUE stall cycle adds one cycle.
- start_i outside IDLE: ignored, and not queued.
- abort_i in ISSUE/WAIT/DONE:
  - Next edge goes to IDLE.
  - Share, rdi and j registers are zeroed.
  - No done_o pulse.
  - Abort takes priority over the round commit and over a handshake in the same cycle; that PRNG word is not accepted (rnd_ready_o is forced to 0 when abort_i=1).
- Masking rules:
  - Share 0 and share 1 are never combined in this block.
  - rdi reg is zeroed in IDLE one cycle after DONE.
- Round-index boundary: after the final commit with NROUNDS=12, j reg holds 13'h1000. It is not used further.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT, round 5 -> same cycle: state IDLE, done_o=0, rnd_ready_o=0, dp_rdi_en_o=0, dout*=0. After release: dp_rst_o=1 for one cycle, then 0.
- Nominal call: din0=din1=random X (unmasked 0), rnd_valid_i=1 constant, start at cycle 0:
  - rnd_ready_o high in cycles 1,4,…,34;
  - done_o high only in cycle 37;
  - dout0^dout1 equals the golden Xoodoo[12] of the all-zero state.
- Round index: same run -> dp_j_o = 0x001,0x002,…,0x800 in rounds 0..11; datapath round constant in round 0 = 0x58.
- Stall: rnd_valid_i low for 5 cycles at the round-3 ISSUE:
  - dp_rdi_en_o stays 0 during the stall;
  - done_o moves to cycle 42;
  - unmasked result identical to the nominal run.
- Abort: abort_i=1 in the second WAIT cycle of round 6, rnd_valid_i=1 ->
  - next cycle: IDLE, ready_o=1, shares 0, dp_rst_o=1 for one cycle;
  - no done_o;
  - a following start gives a correct result at +37.
- Start while busy: pulse start_i at cycle 10 with different din -> ignored; dout is unchanged and done_o is still at cycle 37.
